// File: rtl/mix_columns_iter_if.sv
// Handshake and data bus of the MixColumns round stage.
// The requester drives Mix_En/Text; the stage returns Modified_Text/Mix_Ry.
interface mix_columns_iter_if;
  logic         Mix_En;
  logic [127:0] Text;
  logic [127:0] Modified_Text;
  logic         Mix_Ry;

  modport master (output Mix_En, Text, input Modified_Text, Mix_Ry);
  modport slave  (input Mix_En, Text, output Modified_Text, Mix_Ry);
endinterface

// File: rtl/mix_columns_iter.sv
// AES forward MixColumns, LANES columns per clock, Mix_En/Mix_Ry level handshake.
// Partial columns build up in acc; Modified_Text is written only with a complete result.
module mix_col_lane (
  input  logic [31:0] col,
  output logic [31:0] mixed
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col;

  assign mixed = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                  xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
endmodule

module mix_columns_iter #(
  parameter int LANES = 1
) (
  input  logic               Clk,
  input  logic               Rst_n,
  mix_columns_iter_if.slave  bus
);
  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("mix_columns_iter: LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state;
  logic [1:0]   cnt;
  logic [127:0] work;
  logic [127:0] acc;
  logic [127:0] mod_text;
  logic         ry;

  logic [127:0]                src;
  logic [127:0]                acc_next;
  logic [LANES-1:0][1:0]       idx;
  logic [LANES-1:0][31:0]      col_in;
  logic [LANES-1:0][31:0]      col_out;
  logic                        last;
  logic [1:0]                  cnt_next;

  // The first slice comes straight from the bus so LANES=4 finishes in one edge.
  assign src = (state == IDLE) ? bus.Text : work;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    // Column c sits at bits [127-32c -: 32]; ~idx selects that word.
    assign idx[i]    = cnt + 2'(i);
    assign col_in[i] = src[{~idx[i], 5'b0} +: 32];
    mix_col_lane u_lane (.col(col_in[i]), .mixed(col_out[i]));
  end

  always_comb begin
    acc_next = acc;
    for (int i = 0; i < LANES; i++)
      acc_next[{~idx[i], 5'b0} +: 32] = col_out[i];
  end

  assign last     = ({1'b0, cnt} + 3'(LANES)) == 3'd4;
  assign cnt_next = cnt + 2'(LANES);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      work     <= '0;
      acc      <= '0;
      mod_text <= '0;
      ry       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.Mix_En) begin
          work <= bus.Text;
          acc  <= acc_next;
          if (last) begin
            state    <= DONE;
            mod_text <= acc_next;
            ry       <= 1'b1;
          end else begin
            state <= BUSY;
            cnt   <= cnt_next;
          end
        end
        BUSY: if (!bus.Mix_En) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          acc <= acc_next;
          if (last) begin
            state    <= DONE;
            cnt      <= '0;
            mod_text <= acc_next;
            ry       <= 1'b1;
          end else begin
            cnt <= cnt_next;
          end
        end
        DONE: if (!bus.Mix_En) begin
          state <= IDLE;
          ry    <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          ry    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Modified_Text = mod_text;
  assign bus.Mix_Ry        = ry;
endmodule

// File: tb/tb_mix_columns_iter.sv
// Random and directed checks of mix_columns_iter against a GF(2^8) matrix model.
// The abort sequence assumes the default LANES=1.
module tb_mix_columns_iter;
  localparam int LANES = 1;
  localparam int LAT   = 4 / LANES;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  mix_columns_iter_if bus ();

  mix_columns_iter #(.LANES(LANES)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [127:0] prev;

  localparam logic [127:0] VEC_A = 128'h64a9a7e632f001d9cce556cbc5464882;
  localparam logic [127:0] VEC_B = 128'h6b3e1c92f1c8d001835238513b6fd3e7;
  localparam logic [127:0] VEC_C = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] RES_C = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // Row r of the circulant matrix is [02 03 01 01] rotated right by r.
  function automatic logic [127:0] mix_ref(input logic [127:0] t);
    logic [7:0] coef [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    logic [7:0] s [16];
    logic [7:0] o;
    logic [127:0] r = '0;
    for (int b = 0; b < 16; b++) s[b] = t[127 - 8*b -: 8];
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++) o ^= gmul(coef[(j - row + 4) % 4], s[4*c + j]);
        r[127 - 8*(4*c + row) -: 8] = o;
      end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Runs one operation; if swap is set, Text is replaced after the capture edge.
  task automatic run_op(input string tag, input logic [127:0] t, input logic [127:0] exp,
                        input bit swap);
    int n = 0;
    chk({tag, "_ry_idle"}, 128'(bus.Mix_Ry), 128'(0));
    bus.Text   = t;
    bus.Mix_En = 1'b1;
    while (n < 20) begin
      tick();
      n++;
      if (swap) bus.Text = 128'({$urandom, $urandom, $urandom, $urandom});
      if (bus.Mix_Ry) break;
    end
    chk({tag, "_lat"}, 128'(n), 128'(LAT));
    chk({tag, "_res"}, bus.Modified_Text, exp);
    tick();
    chk({tag, "_hold"}, bus.Modified_Text, exp);
    bus.Mix_En = 1'b0;
    tick();
    chk({tag, "_ry_drop"}, 128'(bus.Mix_Ry), 128'(0));
    chk({tag, "_kept"}, bus.Modified_Text, exp);
    prev = exp;
  endtask

  initial begin
    bus.Mix_En = 1'b1;
    bus.Text   = VEC_A;
    prev       = '0;

    // reset held with a pending request
    repeat (3) tick();
    chk("rst_ry", 128'(bus.Mix_Ry), 128'(0));
    chk("rst_mt", bus.Modified_Text, 128'(0));
    Rst_n = 1'b1;
    run_op("vec_a", VEC_A, mix_ref(VEC_A), 1'b0);
    run_op("vec_b", VEC_B, mix_ref(VEC_B), 1'b0);
    run_op("vec_c", VEC_C, RES_C, 1'b0);

    for (int i = 0; i < 12; i++) begin
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      run_op("rand", t, mix_ref(t), 1'b0);
    end

    // abort after two busy edges: no result, old output preserved
    bus.Text   = VEC_A;
    bus.Mix_En = 1'b1;
    repeat (2) begin
      tick();
      chk("abort_ry_busy", 128'(bus.Mix_Ry), 128'(0));
    end
    bus.Mix_En = 1'b0;
    repeat (3) begin
      tick();
      chk("abort_ry", 128'(bus.Mix_Ry), 128'(0));
      chk("abort_mt", bus.Modified_Text, prev);
    end
    run_op("restart", VEC_A, mix_ref(VEC_A), 1'b0);

    // Text scrambled every cycle after capture
    for (int i = 0; i < 4; i++) begin
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      run_op("swap", t, mix_ref(t), 1'b1);
    end

    // asynchronous reset mid-operation
    bus.Text   = VEC_B;
    bus.Mix_En = 1'b1;
    repeat (2) tick();
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_ry", 128'(bus.Mix_Ry), 128'(0));
    chk("arst_mt", bus.Modified_Text, 128'(0));
    bus.Mix_En = 1'b0;
    tick();
    Rst_n = 1'b1;
    tick();
    run_op("post_rst", VEC_B, mix_ref(VEC_B), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
